// File: rtl/tictactoe_move_gen_if.sv
// Signal bundle between the tic-tac-toe game core side and the computer-move
// generator.
//   start             move request into the generator
//   pos1..pos9        board cells (00 empty, 01 player, 10 computer, 11 occupied)
//   who               game status (00 in progress, 01/10 won, 11 draw)
//   computer_position chosen cell index 0..8, from the generator
//   pc                move strobe, from the generator
//   busy              generator is searching or issuing
//   no_move           one-cycle pulse when the board had no empty cell
// The master modport is the core/controller side; the slave modport is the
// move generator.
interface tictactoe_move_gen_if;
  logic       start;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [1:0] who;
  logic [3:0] computer_position;
  logic       pc;
  logic       busy;
  logic       no_move;

  modport master (
    output start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
    input  computer_position, pc, busy, no_move
  );

  modport slave (
    input  start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
    output computer_position, pc, busy, no_move
  );
endinterface

// File: rtl/tictactoe_move_gen.sv
// Computer-move generator for the tic-tac-toe core. On start (game in
// progress) it snapshots the board, scans the eight lines one per cycle for a
// winning move, then for a blocking move, then takes the first empty cell in
// the order centre, corners, edges. The chosen cell is driven on
// computer_position with pc held high for HOLD_CYCLES cycles.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    slave side of tictactoe_move_gen_if (start/pos*/who in,
//          computer_position/pc/busy/no_move out, all outputs registered)
module tictactoe_move_gen #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input logic                 clock,
  input logic                 reset,
  tictactoe_move_gen_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WIN, BLOCK, FALLBACK, ISSUE} state_t;

  localparam logic [3:0] FB_ORDER [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8,
                                          4'd1, 4'd3, 4'd5, 4'd7};

  state_t     state;
  logic [1:0] snap [9];
  logic [2:0] line;
  logic [3:0] hold;
  logic [3:0] position_r;
  logic       pc_r;
  logic       busy_r;
  logic       no_move_r;

  logic [1:0] cells [9];
  logic [3:0] la, lb, lc;
  logic [1:0] ca, cb, cc;
  logic       win_match, block_match;
  logic [3:0] empty_idx;
  logic       fb_found;
  logic [3:0] fb_idx;
  logic       hit;
  logic [3:0] hit_idx;

  function automatic logic two_and_empty(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c, input logic [1:0] v);
    return (a == v && b == v && c == 2'b00) ||
           (a == v && c == v && b == 2'b00) ||
           (b == v && c == v && a == 2'b00);
  endfunction

  always_comb begin
    cells[0] = bus.pos1;
    cells[1] = bus.pos2;
    cells[2] = bus.pos3;
    cells[3] = bus.pos4;
    cells[4] = bus.pos5;
    cells[5] = bus.pos6;
    cells[6] = bus.pos7;
    cells[7] = bus.pos8;
    cells[8] = bus.pos9;
  end

  // Line table: rows, columns, then the two diagonals.
  always_comb begin
    la = 4'd0;
    lb = 4'd1;
    lc = 4'd2;
    case (line)
      3'd0: begin la = 4'd0; lb = 4'd1; lc = 4'd2; end
      3'd1: begin la = 4'd3; lb = 4'd4; lc = 4'd5; end
      3'd2: begin la = 4'd6; lb = 4'd7; lc = 4'd8; end
      3'd3: begin la = 4'd0; lb = 4'd3; lc = 4'd6; end
      3'd4: begin la = 4'd1; lb = 4'd4; lc = 4'd7; end
      3'd5: begin la = 4'd2; lb = 4'd5; lc = 4'd8; end
      3'd6: begin la = 4'd0; lb = 4'd4; lc = 4'd8; end
      default: begin la = 4'd2; lb = 4'd4; lc = 4'd6; end
    endcase
  end

  always_comb begin
    ca          = snap[la];
    cb          = snap[lb];
    cc          = snap[lc];
    win_match   = two_and_empty(ca, cb, cc, 2'b10);
    block_match = two_and_empty(ca, cb, cc, 2'b01);
    // Only meaningful on a match, where exactly one cell is empty.
    empty_idx   = (ca == 2'b00) ? la : ((cb == 2'b00) ? lb : lc);
  end

  always_comb begin
    fb_found = 1'b0;
    fb_idx   = 4'd0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (!fb_found && snap[FB_ORDER[i]] == 2'b00) begin
        fb_found = 1'b1;
        fb_idx   = FB_ORDER[i];
      end
    end
  end

  // One "move found" view across the three search states so the issue
  // entry is written once in the FSM.
  always_comb begin
    hit     = 1'b0;
    hit_idx = empty_idx;
    case (state)
      WIN:      hit = win_match;
      BLOCK:    hit = block_match;
      FALLBACK: begin
        hit     = fb_found;
        hit_idx = fb_idx;
      end
      default:  hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      line       <= '0;
      hold       <= '0;
      position_r <= '0;
      pc_r       <= 1'b0;
      busy_r     <= 1'b0;
      no_move_r  <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) snap[i] <= '0;
    end else begin
      no_move_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.who == 2'b00) begin
            for (int unsigned i = 0; i < 9; i++) snap[i] <= cells[i];
            line   <= '0;
            busy_r <= 1'b1;
            state  <= WIN;
          end
        end
        WIN, BLOCK, FALLBACK: begin
          if (hit) begin
            position_r <= hit_idx;
            pc_r       <= 1'b1;
            hold       <= 4'(HOLD_CYCLES - 1);
            state      <= ISSUE;
          end else if (state == FALLBACK) begin
            no_move_r <= 1'b1;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end else if (line == 3'd7) begin
            line  <= '0;
            state <= (state == WIN) ? BLOCK : FALLBACK;
          end else begin
            line <= line + 3'd1;
          end
        end
        ISSUE: begin
          if (hold == 4'd0) begin
            pc_r   <= 1'b0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            hold <= hold - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.computer_position = position_r;
  assign bus.pc                = pc_r;
  assign bus.busy              = busy_r;
  assign bus.no_move           = no_move_r;

endmodule

// File: tb/tb_tictactoe_move_gen.sv
// Self-checking bench for tictactoe_move_gen: expected moves are queued when
// a start is driven and popped when pc or no_move appears.
module tb_tictactoe_move_gen;

  localparam int unsigned HOLD = 4;

  logic clock = 1'b0;
  logic reset;

  tictactoe_move_gen_if bus ();

  tictactoe_move_gen #(.HOLD_CYCLES(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_move;
    logic [3:0] pos;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  int lines_t [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                         '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};
  int fb_t [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

  function automatic logic [17:0] put(input logic [17:0] b, input int idx,
                                      input logic [1:0] v);
    logic [17:0] r;
    r = b;
    r[2*idx +: 2] = v;
    return r;
  endfunction

  // Reference strategy: win scan, block scan, then fallback order.
  function automatic void model(input logic [17:0] b, output bit mv,
                                output logic [3:0] p, output int lat);
    logic [1:0] v;
    logic [1:0] c;
    int nv, ne, e;
    mv = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      v = (pass == 0) ? 2'b10 : 2'b01;
      for (int k = 0; k < 8; k++) begin
        nv = 0; ne = 0; e = 0;
        for (int j = 0; j < 3; j++) begin
          c = b[2*lines_t[k][j] +: 2];
          if (c == v) nv++;
          if (c == 2'b00) begin ne++; e = lines_t[k][j]; end
        end
        if (nv == 2 && ne == 1) begin
          p = 4'(e);
          lat = pass * 8 + k + 1;
          return;
        end
      end
    end
    for (int i = 0; i < 9; i++) begin
      if (b[2*fb_t[i] +: 2] == 2'b00) begin
        p = 4'(fb_t[i]);
        lat = 17;
        return;
      end
    end
    mv = 1'b0;
    p = 4'd0;
    lat = 17;
  endfunction

  task automatic set_board(input logic [17:0] b);
    bus.pos1 = b[1:0];
    bus.pos2 = b[3:2];
    bus.pos3 = b[5:4];
    bus.pos4 = b[7:6];
    bus.pos5 = b[9:8];
    bus.pos6 = b[11:10];
    bus.pos7 = b[13:12];
    bus.pos8 = b[15:14];
    bus.pos9 = b[17:16];
  endtask

  // Drives one start and checks the resulting move/no_move against the
  // queued expectation. Optionally keeps start high, or disturbs the board
  // and who right after the start is accepted.
  task automatic run_move(input string name, input bit mv, input logic [3:0] p,
                          input int lat, input bit keep_start, input bit change,
                          input logic [17:0] alt);
    exp_t e;
    int n;
    bit seen, obs_mv, stable;
    int held;
    logic [3:0] p_obs;
    e.is_move = mv;
    e.pos = p;
    e.lat = lat;
    @(negedge clock);
    sb.push_back(e);
    bus.start = 1'b1;
    @(posedge clock); #1;
    if (!keep_start) bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL %s busy_after_start got=%b exp=1", name, bus.busy);
    else passes++;
    if (change) begin
      set_board(alt);
      bus.who = 2'b01;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (bus.pc === 1'b1 || bus.no_move === 1'b1) seen = 1'b1;
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++;
      $display("FAIL %s timeout got=no_output exp=output_within_40", name);
    end else begin
      obs_mv = (bus.pc === 1'b1);
      checks++;
      if (obs_mv !== e.is_move) $display("FAIL %s kind got_pc=%b exp_pc=%b", name, obs_mv, e.is_move);
      else passes++;
      checks++;
      if (n !== e.lat) $display("FAIL %s latency got=E%0d exp=E%0d", name, n, e.lat);
      else passes++;
      if (obs_mv) begin
        checks++;
        if (bus.computer_position !== e.pos)
          $display("FAIL %s position got=%0d exp=%0d", name, bus.computer_position, e.pos);
        else passes++;
        held = 1;
        stable = 1'b1;
        p_obs = bus.computer_position;
        for (int k = 0; k < 20; k++) begin
          @(posedge clock); #1;
          if (bus.pc !== 1'b1) break;
          held++;
          if (bus.computer_position !== p_obs) stable = 1'b0;
        end
        checks++;
        if (held != int'(HOLD)) $display("FAIL %s pc_width got=%0d exp=%0d", name, held, HOLD);
        else passes++;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL %s busy_at_pc_drop got=%b exp=0", name, bus.busy);
        else passes++;
        checks++;
        if (!stable) $display("FAIL %s position_stable got=changed exp=stable", name);
        else passes++;
      end else begin
        @(posedge clock); #1;
        checks++;
        if (bus.no_move !== 1'b0 || bus.pc !== 1'b0 || bus.busy !== 1'b0)
          $display("FAIL %s after_no_move got=nm%b pc%b busy%b exp=nm0 pc0 busy0",
                   name, bus.no_move, bus.pc, bus.busy);
        else passes++;
      end
    end
    if (change) bus.who = 2'b00;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.computer_position !== 4'd0 || bus.pc !== 1'b0 || bus.busy !== 1'b0 ||
        bus.no_move !== 1'b0)
      $display("FAIL reset_outputs got=pos%0d pc%b busy%b nm%b exp=0", bus.computer_position,
               bus.pc, bus.busy, bus.no_move);
    else passes++;
  endtask

  task automatic test_win();
    logic [17:0] b;
    b = put(put(put(put(18'd0, 0, 2'b10), 1, 2'b10), 3, 2'b01), 4, 2'b01);
    set_board(b);
    run_move("win", 1'b1, 4'd2, 1, 1'b0, 1'b0, 18'd0);
  endtask

  task automatic test_block();
    logic [17:0] b;
    b = put(put(put(18'd0, 0, 2'b10), 3, 2'b01), 4, 2'b01);
    set_board(b);
    run_move("block", 1'b1, 4'd5, 10, 1'b0, 1'b0, 18'd0);
    b = put(put(b, 6, 2'b10), 7, 2'b10);
    set_board(b);
    run_move("win_beats_block", 1'b1, 4'd8, 3, 1'b0, 1'b0, 18'd0);
  endtask

  task automatic test_fallback();
    logic [17:0] b;
    set_board(18'd0);
    run_move("fallback_empty", 1'b1, 4'd4, 17, 1'b0, 1'b0, 18'd0);
    set_board(put(18'd0, 4, 2'b01));
    run_move("fallback_corner", 1'b1, 4'd0, 17, 1'b0, 1'b0, 18'd0);
    b = put(put(put(put(put(18'd0, 0, 2'b10), 2, 2'b01), 4, 2'b10), 6, 2'b01), 8, 2'b10);
    set_board(b);
    run_move("fallback_edge", 1'b1, 4'd1, 17, 1'b0, 1'b0, 18'd0);
  endtask

  task automatic test_full_board();
    logic [17:0] b;
    b = 18'd0;
    b = put(b, 0, 2'b10); b = put(b, 1, 2'b01); b = put(b, 2, 2'b10);
    b = put(b, 3, 2'b10); b = put(b, 4, 2'b01); b = put(b, 5, 2'b01);
    b = put(b, 6, 2'b01); b = put(b, 7, 2'b10); b = put(b, 8, 2'b11);
    set_board(b);
    run_move("full_board", 1'b0, 4'd0, 17, 1'b0, 1'b0, 18'd0);
  endtask

  task automatic test_who_ignored();
    set_board(18'd0);
    for (int w = 1; w < 4; w++) begin
      @(negedge clock);
      bus.who = 2'(w);
      bus.start = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(posedge clock); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.pc !== 1'b0 || bus.no_move !== 1'b0)
          $display("FAIL who_ignored who=%0d got=busy%b pc%b nm%b exp=0", w, bus.busy,
                   bus.pc, bus.no_move);
        else passes++;
      end
    end
    @(negedge clock);
    bus.start = 1'b0;
    bus.who = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [17:0] wb;
    // Mid-BLOCK: empty board, reset five cycles after BLOCK is entered (E8).
    set_board(18'd0);
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (13) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b1 || bus.computer_position === 4'd0)
      $display("FAIL reset_mid_pre got=busy%b pos%0d exp=busy1 pos_nonzero", bus.busy,
               bus.computer_position);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.pc !== 1'b0 || bus.computer_position !== 4'd0)
      $display("FAIL reset_mid_block got=busy%b pc%b pos%0d exp=0", bus.busy, bus.pc,
               bus.computer_position);
    else passes++;
    @(negedge clock);
    reset = 1'b1;
    // Mid-ISSUE: pc must drop without a clock edge.
    wb = put(put(18'd0, 0, 2'b10), 1, 2'b10);
    set_board(wb);
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #3;
    checks++;
    if (bus.pc !== 1'b1 || bus.computer_position !== 4'd2)
      $display("FAIL reset_issue_pre got=pc%b pos%0d exp=pc1 pos2", bus.pc, bus.computer_position);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.pc !== 1'b0 || bus.computer_position !== 4'd0)
      $display("FAIL reset_mid_issue got=busy%b pc%b pos%0d exp=0", bus.busy, bus.pc,
               bus.computer_position);
    else passes++;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.pc !== 1'b0)
      $display("FAIL reset_idle_after got=busy%b pc%b exp=0", bus.busy, bus.pc);
    else passes++;
    run_move("after_reset", 1'b1, 4'd2, 1, 1'b0, 1'b0, 18'd0);
  endtask

  task automatic test_start_held();
    exp_t e;
    set_board(put(put(18'd0, 0, 2'b10), 1, 2'b10));
    run_move("held_first", 1'b1, 4'd2, 1, 1'b1, 1'b0, 18'd0);
    // Now just after the pc-drop edge with start still high.
    e.is_move = 1'b1; e.pos = 4'd2; e.lat = 1;
    sb.push_back(e);
    @(posedge clock); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.pc !== 1'b0)
      $display("FAIL held_reaccept got=busy%b pc%b exp=busy1 pc0", bus.busy, bus.pc);
    else passes++;
    @(posedge clock); #1;
    e = sb.pop_front();
    checks++;
    if (bus.pc !== e.is_move || bus.computer_position !== e.pos)
      $display("FAIL held_second got=pc%b pos%0d exp=pc1 pos%0d", bus.pc,
               bus.computer_position, e.pos);
    else passes++;
    repeat (HOLD + 3) @(posedge clock);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.pc !== 1'b0)
      $display("FAIL held_no_queue got=busy%b pc%b exp=0", bus.busy, bus.pc);
    else passes++;
  endtask

  task automatic test_snapshot();
    logic [17:0] b, alt;
    b = put(put(put(18'd0, 0, 2'b10), 3, 2'b01), 4, 2'b01);
    alt = put(put(18'd0, 0, 2'b10), 1, 2'b10);
    set_board(b);
    run_move("snapshot", 1'b1, 4'd5, 10, 1'b0, 1'b1, alt);
  endtask

  task automatic test_random();
    logic [17:0] b;
    bit mv;
    logic [3:0] p;
    int lat;
    for (int r = 0; r < 6; r++) begin
      b = 18'd0;
      for (int i = 0; i < 9; i++) b = put(b, i, 2'($urandom_range(0, 3)));
      model(b, mv, p, lat);
      set_board(b);
      run_move("random", mv, p, lat, 1'b0, 1'b0, 18'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.who = 2'b00;
    set_board(18'd0);
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset = 1'b1;
    test_win();
    test_block();
    test_fallback();
    test_full_board();
    test_who_ignored();
    test_reset_mid();
    test_start_held();
    test_snapshot();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
